// File: rtl/wrr_burst_arbiter_if.sv
// Requester/arbiter handshake bundle for wrr_burst_arbiter.
// The arbiter side uses the slave modport.
interface wrr_burst_arbiter_if;
  logic       arb_en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       reload_pulse;

  modport master (output arb_en, req, input gnt, gnt_id, busy, reload_pulse);
  modport slave  (input arb_en, req, output gnt, gnt_id, busy, reload_pulse);
endinterface

// File: rtl/wrr_burst_arbiter.sv
// 4-way weighted round-robin arbiter with burst hold and max-hold preemption.
// Optional starvation override is enabled by defining WRR_STARVE_EN.
module wrr_burst_arbiter_lane #(
  parameter int WW           = 3,
  parameter int STARVE_LIMIT = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reload,
  input  logic          take,
  input  logic [WW-1:0] weight,
  input  logic          req,
  input  logic          gnt,
  output logic          credit_nz,
  output logic          starved
);
  logic [WW-1:0] credit_q, credit_d, base;

  // Weight 0 reloads as 1; a starved winner with no credit stays at 0.
  always_comb begin
    base     = reload ? ((weight == '0) ? WW'(1) : weight) : credit_q;
    credit_d = (take && base != '0) ? base - WW'(1) : base;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) credit_q <= '0;
    else        credit_q <= credit_d;

  assign credit_nz = (credit_q != '0);

`ifdef WRR_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (gnt)                                        wait_d = '0;
    else if (req && wait_q < SW'(STARVE_LIMIT))     wait_d = wait_q + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;

  assign starved = (wait_q >= SW'(STARVE_LIMIT));
`else
  logic unused_lane;
  assign unused_lane = req ^ gnt ^ STARVE_LIMIT[0];
  assign starved     = 1'b0;
`endif
endmodule

module wrr_burst_arbiter #(
  parameter int WW           = 3,
  parameter int HW           = 4,
  parameter int STARVE_LIMIT = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  wrr_burst_arbiter_if.slave  bus,
  input  logic [4*WW-1:0]     cfg_weight,
  input  logic [HW-1:0]       cfg_max_hold
);
  localparam int NUM_LANES = 4;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             ptr_q, ptr_d, gnt_id_q, gnt_id_d, sel, idx;
  logic [NUM_LANES-1:0]   gnt_q, gnt_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [NUM_LANES-1:0]   credit_nz, starved, elig, cand, take, others;
  logic                   reload, found, preempt;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    wrr_burst_arbiter_lane #(.WW(WW), .STARVE_LIMIT(STARVE_LIMIT)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .reload    (reload),
      .take      (take[i]),
      .weight    (cfg_weight[i*WW +: WW]),
      .req       (bus.req[i]),
      .gnt       (gnt_d[i]),
      .credit_nz (credit_nz[i]),
      .starved   (starved[i])
    );
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    hold_d   = hold_q;
    reload   = 1'b0;
    take     = '0;
    sel      = '0;
    idx      = '0;
    found    = 1'b0;
    preempt  = 1'b0;
    elig     = bus.req & credit_nz;
    cand     = '0;
    others   = bus.req & ~gnt_q;
    case (state_q)
      IDLE: begin
        if (bus.arb_en && bus.req != '0) begin
          // Nobody eligible: refill in the same cycle, then every requester is eligible.
          if (elig == '0) begin
            reload = 1'b1;
            elig   = bus.req;
          end
          cand = ((bus.req & starved) != '0) ? (bus.req & starved) : elig;
          for (int k = 0; k < NUM_LANES; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && cand[idx]) begin
              found = 1'b1;
              sel   = idx;
            end
          end
          take[sel] = 1'b1;
          gnt_d     = 4'b0001 << sel;
          gnt_id_d  = sel;
          ptr_d     = sel + 2'd1;
          hold_d    = '0;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        hold_d  = (hold_q == '1) ? hold_q : hold_q + HW'(1);
        preempt = (others != '0) &&
                  ((cfg_max_hold != '0 && hold_q >= cfg_max_hold - HW'(1)) ||
                   ((others & starved) != '0));
        if (!bus.req[gnt_id_q] || preempt) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.gnt_id       = gnt_id_q;
  assign bus.busy         = (state_q == GRANT);
  // Reload is a decision-cycle event; held low while reset is asserted.
  assign bus.reload_pulse = reload & rst_n;
endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Bench for wrr_burst_arbiter: directed scenarios plus random requesters,
// every cycle checked against a credit/pointer reference model.
module tb_wrr_burst_arbiter;
  localparam int WW = 3;
  localparam int HW = 4;
  localparam int SL = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [4*WW-1:0] cfg_weight;
  logic [HW-1:0]   cfg_max_hold;

  wrr_burst_arbiter_if bus();

  wrr_burst_arbiter #(.WW(WW), .HW(HW), .STARVE_LIMIT(SL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .cfg_weight   (cfg_weight),
    .cfg_max_hold (cfg_max_hold)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: credits, rotating pointer, current holder.
  int         cred[4];
  int         m_wait[4];
  int         ptr, m_id, hold;
  bit         m_busy;
  logic [3:0] m_gnt;

  function automatic int wt(input int i);
    int w;
    w = int'(cfg_weight[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic bit m_reload();
    if (m_busy || !bus.arb_en || bus.req == 4'b0) return 1'b0;
    for (int i = 0; i < 4; i++) if (bus.req[i] && cred[i] > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin cred[i] = 0; m_wait[i] = 0; end
    ptr = 0; m_id = 0; hold = 0; m_busy = 1'b0; m_gnt = 4'b0;
  endtask

  task automatic model_edge();
    logic [3:0] r;
    bit others, pre;
    int sel, j;
    r = bus.req;
    if (m_busy) begin
      others = (r & ~m_gnt) != 4'b0;
      pre = others && cfg_max_hold != 0 && hold >= int'(cfg_max_hold) - 1;
`ifdef WRR_STARVE_EN
      for (int i = 0; i < 4; i++) if (i != m_id && r[i] && m_wait[i] >= SL) pre = 1'b1;
`endif
      if (!r[m_id] || pre) begin m_busy = 1'b0; m_gnt = 4'b0; end
      hold = (hold < 15) ? hold + 1 : 15;
    end else if (bus.arb_en && r != 4'b0) begin
      sel = -1;
      if (m_reload()) for (int i = 0; i < 4; i++) cred[i] = wt(i);
`ifdef WRR_STARVE_EN
      for (int k = 0; k < 4; k++) begin
        j = (ptr + k) % 4;
        if (sel < 0 && r[j] && m_wait[j] >= SL) sel = j;
      end
`endif
      for (int k = 0; k < 4; k++) begin
        j = (ptr + k) % 4;
        if (sel < 0 && r[j] && cred[j] > 0) sel = j;
      end
      if (cred[sel] > 0) cred[sel]--;
      ptr = (sel + 1) % 4; m_busy = 1'b1; m_id = sel; hold = 0;
      m_gnt = 4'(1 << sel);
    end
`ifdef WRR_STARVE_EN
    for (int i = 0; i < 4; i++)
      if (m_gnt[i]) m_wait[i] = 0;
      else if (r[i] && m_wait[i] < SL) m_wait[i]++;
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("gnt", 32'(bus.gnt), 32'(m_gnt));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("reload_pulse", 32'(bus.reload_pulse), 32'(m_reload()));
    if (m_gnt != 4'b0) chk("gnt_id", 32'(bus.gnt_id), 32'(m_id));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 4'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_gnt_id", 32'(bus.gnt_id), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_reload", 32'(bus.reload_pulse), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int order[$];
    int exp_order[7];
    int gap, n;
    logic [3:0] r;
    exp_order = '{0, 1, 2, 3, 0, 0, 1};
    bus.arb_en = 1'b1;
    bus.req = 4'b0;
    cfg_weight = 12'h249;
    cfg_max_hold = '0;
    model_reset();
    @(negedge clk);

    // Single requester, weights all 1
    do_reset();
    bus.req = 4'b0001;
    #1 chk("t1_reload_decision", 32'(bus.reload_pulse), 1);
    cyc(); chk("t1_gnt", 32'(bus.gnt), 32'h1);
    cyc(); cyc();
    bus.req = 4'b0000;
    cyc(); chk("t1_drop", 32'(bus.gnt), 0);

    // Weights m0=3, others 1; one-cycle grants, requests re-raised at once
    do_reset();
    cfg_weight = {3'd1, 3'd1, 3'd1, 3'd3};
    bus.req = 4'b1111;
    gap = 0;
    for (int c = 0; c < 14; c++) begin
      cyc();
      if (bus.gnt != 4'b0) begin
        if (order.size() > 0) chk("t2_gap", gap, 1);
        order.push_back(int'(bus.gnt_id));
        gap = 0;
        bus.req = 4'b1111 & ~bus.gnt;
      end else begin
        gap++;
        bus.req = 4'b1111;
      end
    end
    chk("t2_count", order.size(), 7);
    for (int i = 0; i < 7 && i < order.size(); i++) chk("t2_order", order[i], exp_order[i]);
    bus.req = 4'b0; cyc();

    // Max-hold 4 preempts m2 when m1 is waiting
    do_reset();
    cfg_weight = 12'h249;
    cfg_max_hold = 4'd4;
    bus.req = 4'b0100;
    cyc(); chk("t3_gnt_m2", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0110;
    n = 1;
    while (bus.gnt == 4'b0100 && n < 20) begin
      cyc();
      if (bus.gnt == 4'b0100) n++;
    end
    chk("t3_hold_len", n, 4);
    chk("t3_gap", 32'(bus.gnt), 0);
    cyc(); chk("t3_gnt_m1", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0100;
    repeat (3) cyc();

    // Max-hold 0: no preemption
    do_reset();
    cfg_max_hold = 4'd0;
    bus.req = 4'b0100;
    cyc();
    bus.req = 4'b0110;
    repeat (6) cyc();
    chk("t4_still_m2", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0010;
    cyc(); chk("t4_release", 32'(bus.gnt), 0);
    cyc(); chk("t4_gnt_m1", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0; cyc();

    // arb_en low mid-grant
    do_reset();
    bus.req = 4'b0011;
    cyc(); chk("t5_gnt_m0", 32'(bus.gnt), 32'h1);
    bus.arb_en = 1'b0;
    cyc(); chk("t5_continues", 32'(bus.gnt), 32'h1);
    cyc();
    bus.req = 4'b0010;
    cyc(); chk("t5_release", 32'(bus.gnt), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("t5_no_grant", 32'(bus.gnt), 0);
    end
    bus.arb_en = 1'b1;
    cyc(); chk("t5_gnt_m1", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0; cyc();

    // Async reset while m2 holds the grant
    do_reset();
    bus.req = 4'b0100;
    cyc(); chk("t6_gnt_m2", 32'(bus.gnt), 32'h4);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_gnt", 32'(bus.gnt), 0);
    chk("t6_async_busy", 32'(bus.busy), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t6_reload_after_rst", 32'(bus.reload_pulse), 1);
    cyc(); chk("t6_regrant", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0; cyc();

    // Random requesters honouring the hold-until-granted protocol
    cfg_max_hold = 4'd3;
    for (int c = 0; c < 1500; c++) begin
      r = bus.req;
      for (int i = 0; i < 4; i++) begin
        if (!r[i]) begin
          if ($urandom_range(2) == 0) r[i] = 1'b1;
        end else if (bus.gnt[i] && $urandom_range(2) == 0) begin
          r[i] = 1'b0;
        end
      end
      bus.req = r;
      bus.arb_en = ($urandom_range(9) != 0);
      if ($urandom_range(31) == 0) cfg_max_hold = 4'($urandom_range(6));
      if ($urandom_range(63) == 0) cfg_weight = 12'($urandom);
      if ($urandom_range(499) == 0) do_reset();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
